regfile_2w2r: RTL
=================

// Module: regfile_2w2r
// PURPOSE
//  Parametrised register file: 2 write ports, 2 read ports, asynchronous reads.
//  Optional hardwired zero register and optional write-to-read bypass.
//  Registered conflict flag when both write ports target the same register.
//  Drop-in successor for the CPU datapath register file; 2nd write port serves load/writeback.
// PARAMETERS
//  DATA_WIDTH  16  bits per register
//  ADDR_WIDTH  4   address bits; depth = 2**ADDR_WIDTH
//  ZERO_REG    1   1: reg 0 always reads 0, writes to it dropped; 0: reg 0 is ordinary
//  BYPASS      1   1: a read of an address written this cycle returns the write data; 0: returns old contents
// PORTS
//  clk            in   1           clock, all state updates on posedge
//  reset          in   1           synchronous, active-high
//  regWrite1      in   1           write enable, port 1
//  writeAddr1     in   ADDR_WIDTH  write address, port 1
//  writeData1     in   DATA_WIDTH  write data, port 1
//  regWrite2      in   1           write enable, port 2
//  writeAddr2     in   ADDR_WIDTH  write address, port 2
//  writeData2     in   DATA_WIDTH  write data, port 2
//  readAddr1      in   ADDR_WIDTH  read address, port 1
//  readAddr2      in   ADDR_WIDTH  read address, port 2
//  readData1      out  DATA_WIDTH  read data, port 1 (combinational)
//  readData2      out  DATA_WIDTH  read data, port 2 (combinational)
//  writeConflict  out  1           registered: 1 for one cycle after a same-address dual write
// BEHAVIOUR
//  - Reset: on posedge clk with reset=1, all registers <= 0 and writeConflict <= 0.
//    Writes presented that cycle are dropped. Bypass is suppressed while reset=1.
//    During reset, reads return array contents (0 from the cycle after the first reset edge).
//  - Write: on posedge clk with reset=0, mem[writeAddrN] <= writeDataN when regWriteN=1.
//    Write latency is 1 cycle.
//  - Same-address dual write (both enables high, writeAddr1==writeAddr2): port 2 wins.
//    writeConflict <= 1 on that edge, else writeConflict <= 0.
//    With ZERO_REG=1 and address 0, no flag is raised.
//  - Read: readDataN = mem[readAddrN], combinational, zero-cycle latency.
//  - Bypass (BYPASS=1, reset=0):
//    if regWrite2 && writeAddr2==readAddrN, return writeData2;
//    else if regWrite1 && writeAddr1==readAddrN, return writeData1;
//    else return mem. Priority matches the write rule.
//  - ZERO_REG=1: readDataN = 0 whenever readAddrN==0, overriding bypass; writes to reg 0 ignored.
//  - Both read ports may read the same address; results are identical.
//  - No X on outputs after the first reset edge. Addresses are full-range; no out-of-range case.
// TESTING
//  1. reset=1 for 2 cycles, then read all 16 addresses -> every readData = 16'h0000, writeConflict=0.
//  2. Write 3<=16'hBEEF (port 1) and 5<=16'h1234 (port 2) in the same cycle.
//     Next cycle read 3/5 -> readData1=16'hBEEF, readData2=16'h1234, writeConflict=0.
//  3. Both ports write addr 7 (p1 16'hAAAA, p2 16'h5555).
//     -> mem[7]=16'h5555 after the edge, writeConflict=1 for exactly one cycle, then 0.
//  4. BYPASS=1: port 1 writes 9<=16'hC0DE while readAddr1=9 in the same cycle
//     -> readData1=16'hC0DE before the edge. With BYPASS=0 -> old value before, 16'hC0DE after.
//  5. ZERO_REG=1: write 0<=16'hFFFF on both ports -> readData=16'h0000, writeConflict=0.
//     With ZERO_REG=0 -> 16'hFFFF and writeConflict=1.
//  6. Fill 2 with 16'h0042; assert reset together with a write 2<=16'h9999.
//     -> after the edge mem[2]=16'h0000, and no bypass of 16'h9999 during reset.

Source files
------------

// File: rtl/regfile_2w2r.sv
// Two-write / two-read register file with combinational reads.
// Write port 2 has priority over write port 1 on a shared address, optionally
// forwarded to the read ports in the same cycle. Register 0 can be hardwired
// to zero. A registered flag marks cycles that followed a same-address dual write.
module regfile_2w2r #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  regWrite1,
  input  logic [ADDR_WIDTH-1:0] writeAddr1,
  input  logic [DATA_WIDTH-1:0] writeData1,
  input  logic                  regWrite2,
  input  logic [ADDR_WIDTH-1:0] writeAddr2,
  input  logic [DATA_WIDTH-1:0] writeData2,
  input  logic [ADDR_WIDTH-1:0] readAddr1,
  input  logic [ADDR_WIDTH-1:0] readAddr2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic                  writeConflict
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam bit ZERO_EN   = (ZERO_REG != 0);
  localparam bit BYPASS_EN = (BYPASS != 0);

  // Storage is cleared by reset, so it lives in fabric registers rather than block RAM.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  conflict_q;
  logic                  conflict_d;

  // Per-register write decode; port 2 is checked first so it wins a shared address.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam logic [ADDR_WIDTH-1:0] REG_ADDR = ADDR_WIDTH'(gi);
      if (ZERO_EN && (gi == 0)) begin : g_zero
        assign mem_d[gi] = '0;
      end else begin : g_rw
        assign mem_d[gi] = (regWrite2 && (writeAddr2 == REG_ADDR)) ? writeData2 :
                           (regWrite1 && (writeAddr1 == REG_ADDR)) ? writeData1 :
                           mem_q[gi];
      end
    end
  endgenerate

  // A dual write to the hardwired zero register is a no-op, so it is not a conflict.
  always_comb begin
    conflict_d = regWrite1 && regWrite2 && (writeAddr1 == writeAddr2) &&
                 !(ZERO_EN && (writeAddr1 == '0));
  end

  // Register array update; reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Conflict flag: high for exactly the cycle after a same-address dual write.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign writeConflict = conflict_q;

  // Read selection: zero register overrides forwarding, forwarding overrides storage.
  // Everything is passed as arguments so callers stay sensitive to every input.
  function automatic logic [DATA_WIDTH-1:0] read_mux(
    input logic [ADDR_WIDTH-1:0] ra,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  rst,
    input logic                  we1,
    input logic [ADDR_WIDTH-1:0] wa1,
    input logic [DATA_WIDTH-1:0] wd1,
    input logic                  we2,
    input logic [ADDR_WIDTH-1:0] wa2,
    input logic [DATA_WIDTH-1:0] wd2
  );
    logic [DATA_WIDTH-1:0] value;
    value = stored;
    if (BYPASS_EN && !rst) begin
      if (we2 && (wa2 == ra)) begin
        value = wd2;
      end else if (we1 && (wa1 == ra)) begin
        value = wd1;
      end
    end
    if (ZERO_EN && (ra == '0)) begin
      value = '0;
    end
    return value;
  endfunction

  // Read port 1, combinational.
  always_comb begin
    readData1 = read_mux(readAddr1, mem_q[readAddr1], reset,
                         regWrite1, writeAddr1, writeData1,
                         regWrite2, writeAddr2, writeData2);
  end

  // Read port 2, combinational.
  always_comb begin
    readData2 = read_mux(readAddr2, mem_q[readAddr2], reset,
                         regWrite1, writeAddr1, writeData1,
                         regWrite2, writeAddr2, writeData2);
  end

endmodule
